// File: rtl/ahb3lite_sdram_pkg.sv
// ----------------------------------------------------------------------------
// ahb3lite_sdram_pkg
//   Shared types and helpers for the SDRAM port arbiter.
//   - arb_state_t : arbiter FSM state encoding (idle / port grant / refresh)
//   - onehot2bin  : converts a one-hot vector of up to 8 bits into its index
// ----------------------------------------------------------------------------
package ahb3lite_sdram_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_REFRESH = 2'd2
    } arb_state_t;

    // Largest supported requester count; onehot2bin works on this width and
    // callers zero-extend narrower grant vectors.
    localparam int unsigned ARB_MAX_PORTS = 8;

    // Index of the set bit in a one-hot vector. OR-ing every set position's
    // index keeps it a flat mux-free reduction; the result is only meaningful
    // for a one-hot (or all-zero, giving 0) input.
    function automatic logic [2:0] onehot2bin(input logic [ARB_MAX_PORTS-1:0] oh);
        logic [2:0] bin;
        bin = '0;
        for (int i = 0; i < ARB_MAX_PORTS; i++) begin
            if (oh[i]) begin
                bin = bin | 3'(i);
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/sdram_rr_arbiter.sv
// ----------------------------------------------------------------------------
// sdram_rr_arbiter
//   Purely combinational round-robin priority selector. The search starts at
//   the port just above the pointer and wraps around, so the pointer marks
//   the most recently served port.
//
//   Ports:
//     req_i     in  PORTS   request vector
//     ptr_i     in  ID_W    index of the last granted port
//     gnt_oh_o  out PORTS   one-hot winner (all zero when nothing requests)
//     gnt_idx_o out ID_W    binary index of the winner
// ----------------------------------------------------------------------------
module sdram_rr_arbiter
    import ahb3lite_sdram_pkg::*;
#(
    parameter int unsigned PORTS = 2,
    parameter int unsigned ID_W  = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic [PORTS-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [PORTS-1:0] gnt_oh_o,
    output logic [ID_W-1:0]  gnt_idx_o
);

    logic found;

    // NOTE: every signal written in this always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        gnt_oh_o = '0;
        found    = 1'b0;
        // First pass: ports strictly above the pointer.
        for (int i = 0; i < int'(PORTS); i++) begin
            if (!found && req_i[i] && (i > int'(ptr_i))) begin
                gnt_oh_o[i] = 1'b1;
                found       = 1'b1;
            end
        end
        // Second pass (wrap): ports from 0 up to and including the pointer.
        for (int i = 0; i < int'(PORTS); i++) begin
            if (!found && req_i[i] && (i <= int'(ptr_i))) begin
                gnt_oh_o[i] = 1'b1;
                found       = 1'b1;
            end
        end
        gnt_idx_o = ID_W'(onehot2bin(ARB_MAX_PORTS'(gnt_oh_o)));
    end

endmodule

// File: rtl/ahb3lite_sdram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ahb3lite_sdram_port_arbiter
//   Grants the SDRAM command engine to exactly one owner at a time: one of the
//   AHB data ports (round robin, with HMASTLOCK continuation) or auto-refresh.
//   Refresh intervals are queued in a saturating counter; refresh runs when the
//   arbiter is idle with no port requests, and pre-empts ports (and breaks
//   locks) at the next access boundary once the queue is urgent.
//
//   Ports:
//     HCLK, HRESETn    clock, asynchronous active-low reset
//     req_i  [PORTS]   per-port request level, held until its access completes
//     lock_i [PORTS]   per-port lock, keeps grant across consecutive accesses
//     done_i           pulse: current port access finished
//     ref_tick_i       pulse: one refresh interval elapsed
//     ref_ack_i        pulse: one refresh command completed
//     ovf_clr_i        clears ref_overflow_o
//     gnt_o  [PORTS]   one-hot port grant
//     gnt_valid_o      any port granted
//     gnt_id_o         index of granted port, holds last value when idle
//     ref_req_o        refresh request to the command engine
//     ref_pending_o    queued refresh count
//     ref_overflow_o   sticky: tick arrived while the queue was saturated
// ----------------------------------------------------------------------------
module ahb3lite_sdram_port_arbiter
    import ahb3lite_sdram_pkg::*;
#(
    parameter int unsigned PORTS           = 2,
    parameter int unsigned REF_PENDING_MAX = 8,
    parameter int unsigned REF_URGENT      = 4,
    localparam int unsigned ID_W           = (PORTS > 1) ? $clog2(PORTS) : 1,
    localparam int unsigned CNT_W          = $clog2(REF_PENDING_MAX + 1)
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [PORTS-1:0] req_i,
    input  logic [PORTS-1:0] lock_i,
    input  logic             done_i,
    input  logic             ref_tick_i,
    input  logic             ref_ack_i,
    input  logic             ovf_clr_i,
    output logic [PORTS-1:0] gnt_o,
    output logic             gnt_valid_o,
    output logic [ID_W-1:0]  gnt_id_o,
    output logic             ref_req_o,
    output logic [CNT_W-1:0] ref_pending_o,
    output logic             ref_overflow_o
);

    localparam logic [CNT_W-1:0] PEND_MAX    = CNT_W'(REF_PENDING_MAX);
    localparam logic [CNT_W-1:0] PEND_URGENT = CNT_W'(REF_URGENT);
    localparam logic [ID_W-1:0]  PTR_RESET   = ID_W'(PORTS - 1);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [PORTS-1:0] gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             ref_req_q, ref_req_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;

    logic [PORTS-1:0] rr_gnt;
    logic [ID_W-1:0]  rr_idx;
    logic             urgent;
    logic             keep_lock;

    sdram_rr_arbiter #(
        .PORTS (PORTS),
        .ID_W  (ID_W)
    ) u_rr (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (rr_gnt),
        .gnt_idx_o (rr_idx)
    );

    // ------------------------------------------------------------------
    // Pending-refresh counter. Coincident tick and ack cancel out; an ack
    // on an empty queue is dropped; a tick on a full queue flags overflow,
    // and that set takes priority over a same-cycle clear.
    // ------------------------------------------------------------------
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (ref_tick_i && !ref_ack_i) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (ref_ack_i && !ref_tick_i && (pend_q != '0)) begin
            pend_d = pend_q - 1'b1;
        end
    end

    // Decisions use the registered count, so a tick affects arbitration one
    // cycle after it arrives.
    assign urgent = (pend_q >= PEND_URGENT);

    // The owner keeps the bus on done_i only while it still locks and
    // requests, and refresh is not urgent.
    assign keep_lock = |(gnt_q & lock_i & req_i) && !urgent;

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        ref_req_d   = ref_req_q;

        case (state_q)
            ARB_IDLE: begin
                if (urgent || ((pend_q != '0) && (req_i == '0))) begin
                    state_d   = ARB_REFRESH;
                    ref_req_d = 1'b1;
                end else if (|req_i) begin
                    state_d     = ARB_GRANT;
                    gnt_d       = rr_gnt;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = rr_idx;
                    ptr_d       = rr_idx;
                end
            end

            ARB_GRANT: begin
                // A dropped request alone never releases the grant; only the
                // engine's completion does.
                if (done_i && !keep_lock) begin
                    state_d     = ARB_IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                end
            end

            ARB_REFRESH: begin
                // Always return through IDLE so ports get a look-in between
                // back-to-back refreshes unless the queue is urgent.
                if (ref_ack_i) begin
                    state_d   = ARB_IDLE;
                    ref_req_d = 1'b0;
                end
            end

            default: begin
                state_d     = ARB_IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                ref_req_d   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= PTR_RESET;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ref_req_q   <= 1'b0;
            pend_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            ref_req_q   <= ref_req_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
        end
    end

    assign gnt_o          = gnt_q;
    assign gnt_valid_o    = gnt_valid_q;
    assign gnt_id_o       = gnt_id_q;
    assign ref_req_o      = ref_req_q;
    assign ref_pending_o  = pend_q;
    assign ref_overflow_o = ovf_q;

endmodule

// File: tb/tb_ahb3lite_sdram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahb3lite_sdram_port_arbiter
//   Directed bench for the SDRAM port arbiter with PORTS=2, REF_PENDING_MAX=8,
//   REF_URGENT=4. Inputs change 1 ns after a rising edge and outputs are
//   sampled at the same point, so every expectation below refers to the
//   state registered on the edge just passed.
// ----------------------------------------------------------------------------
module tb_ahb3lite_sdram_port_arbiter;

    localparam int unsigned PORTS = 2;

    logic             clk;
    logic             rst_n;
    logic [PORTS-1:0] req;
    logic [PORTS-1:0] lock;
    logic             done;
    logic             tick;
    logic             ack;
    logic             ovf_clr;
    logic [PORTS-1:0] gnt;
    logic             gnt_valid;
    logic [0:0]       gnt_id;
    logic             ref_req;
    logic [3:0]       pending;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    ahb3lite_sdram_port_arbiter #(
        .PORTS           (PORTS),
        .REF_PENDING_MAX (8),
        .REF_URGENT      (4)
    ) dut (
        .HCLK           (clk),
        .HRESETn        (rst_n),
        .req_i          (req),
        .lock_i         (lock),
        .done_i         (done),
        .ref_tick_i     (tick),
        .ref_ack_i      (ack),
        .ovf_clr_i      (ovf_clr),
        .gnt_o          (gnt),
        .gnt_valid_o    (gnt_valid),
        .gnt_id_o       (gnt_id),
        .ref_req_o      (ref_req),
        .ref_pending_o  (pending),
        .ref_overflow_o (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle pulses on the control inputs.
    task automatic pulse_done();
        done = 1'b1; step(); done = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1; step(); tick = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; step(); ack = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = '0; lock = '0; done = 1'b0;
        tick = 1'b0; ack = 1'b0; ovf_clr = 1'b0;
        step(2);
        check("rst_gnt",      32'(gnt),       32'h0);
        check("rst_valid",    32'(gnt_valid), 32'h0);
        check("rst_id",       32'(gnt_id),    32'h0);
        check("rst_ref_req",  32'(ref_req),   32'h0);
        check("rst_pending",  32'(pending),   32'h0);
        check("rst_overflow", 32'(overflow),  32'h0);
        rst_n = 1'b1;
        step();

        // ---- Round robin between two requesting ports ----
        req = 2'b11;
        step();
        check("rr_first_gnt",   32'(gnt),       32'h1);
        check("rr_first_id",    32'(gnt_id),    32'h0);
        check("rr_first_valid", 32'(gnt_valid), 32'h1);
        step();
        check("rr_hold_gnt",    32'(gnt),       32'h1);
        pulse_done();
        check("rr_idle_gap",    32'(gnt),       32'h0);
        check("rr_idle_valid",  32'(gnt_valid), 32'h0);
        check("rr_idle_id",     32'(gnt_id),    32'h0);
        step();
        check("rr_second_gnt",  32'(gnt),       32'h2);
        check("rr_second_id",   32'(gnt_id),    32'h1);
        pulse_done();
        step();
        check("rr_third_gnt",   32'(gnt),       32'h1);
        check("rr_third_id",    32'(gnt_id),    32'h0);

        // ---- Port 1 locked: keeps grant across done pulses ----
        lock = 2'b10;
        pulse_done();
        step();
        check("lock_gnt_p1", 32'(gnt), 32'h2);
        for (int i = 0; i < 3; i++) begin
            pulse_done();
            check($sformatf("lock_keep_id_%0d", i), 32'(gnt_id),    32'h1);
            check($sformatf("lock_keep_v_%0d", i),  32'(gnt_valid), 32'h1);
        end
        lock = 2'b00;
        pulse_done();
        check("unlock_idle", 32'(gnt), 32'h0);
        step();
        check("unlock_p0",   32'(gnt), 32'h1);

        // ---- Urgent refresh breaks a lock at the access boundary ----
        lock = 2'b01;
        for (int i = 0; i < 4; i++) pulse_tick();
        check("urg_pending",   32'(pending), 32'h4);
        check("urg_still_gnt", 32'(gnt),     32'h1);
        check("urg_no_req",    32'(ref_req), 32'h0);
        pulse_done();
        check("urg_release",   32'(gnt),     32'h0);
        check("urg_req_late",  32'(ref_req), 32'h0);
        step();
        check("urg_ref_req",   32'(ref_req), 32'h1);
        step(2);
        check("urg_ref_hold",  32'(ref_req), 32'h1);
        check("urg_no_gnt",    32'(gnt),     32'h0);
        pulse_ack();
        check("urg_ack_pend",  32'(pending), 32'h3);
        check("urg_ack_drop",  32'(ref_req), 32'h0);
        // Not urgent and ports requesting: ports win; pointer was 0 -> port 1.
        step();
        check("post_ref_gnt",  32'(gnt),     32'h2);
        check("post_ref_rr",   32'(ref_req), 32'h0);
        req = 2'b00; lock = 2'b00;
        pulse_done();
        step();
        check("idle_ref_req",  32'(ref_req), 32'h1);
        for (int i = 0; i < 3; i++) begin
            pulse_ack();
            check($sformatf("drain_pend_%0d", i), 32'(pending), 32'(2 - i));
            check($sformatf("drain_drop_%0d", i), 32'(ref_req), 32'h0);
            step();
            check($sformatf("drain_rereq_%0d", i), 32'(ref_req), (i < 2) ? 32'h1 : 32'h0);
        end

        // ---- Single tick with no requests; tick+ack cancel ----
        pulse_tick();
        check("tick_pend",    32'(pending), 32'h1);
        check("tick_req_0",   32'(ref_req), 32'h0);
        step();
        check("tick_req_1",   32'(ref_req), 32'h1);
        tick = 1'b1; ack = 1'b1; step(); tick = 1'b0; ack = 1'b0;
        check("both_pend",    32'(pending), 32'h1);
        check("both_req",     32'(ref_req), 32'h0);
        step();
        pulse_ack();
        check("both_drain",   32'(pending), 32'h0);

        // ---- Saturation and overflow ----
        for (int i = 0; i < 8; i++) pulse_tick();
        check("sat_pend_8",   32'(pending),  32'h8);
        check("sat_ovf_0",    32'(overflow), 32'h0);
        pulse_tick();
        check("sat_pend_9",   32'(pending),  32'h8);
        check("sat_ovf_1",    32'(overflow), 32'h1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check("ovf_clear",    32'(overflow), 32'h0);
        ovf_clr = 1'b1; tick = 1'b1; step(); ovf_clr = 1'b0; tick = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'h1);
        check("ovf_in_ref",   32'(ref_req),  32'h1);

        // ---- Asynchronous reset mid-refresh ----
        #2 rst_n = 1'b0;
        #1;
        check("arst_ref_req",  32'(ref_req),  32'h0);
        check("arst_ref_pend", 32'(pending),  32'h0);
        check("arst_ref_ovf",  32'(overflow), 32'h0);
        step();
        rst_n = 1'b1;
        req = 2'b11;
        step();
        check("arst_p0_first", 32'(gnt), 32'h1);
        pulse_done();
        step();
        check("arst_p1",       32'(gnt), 32'h2);

        // ---- Asynchronous reset mid-grant ----
        #2 rst_n = 1'b0;
        #1;
        check("arst_gnt",       32'(gnt),       32'h0);
        check("arst_gnt_valid", 32'(gnt_valid), 32'h0);
        check("arst_gnt_id",    32'(gnt_id),    32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("arst_regnt",    32'(gnt),    32'h1);
        check("arst_regnt_id", 32'(gnt_id), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
